wht_2d_arb: RTL
===============

Name: wht_2d_arb

Overview:
- Time-shares one wht_2d engine (4x4 block, 4 row beats in, 4 row beats out) between the forward path (raw pixel blocks) and the reverse path (filtered coefficient blocks) of the denoising pipeline.
- Arbitrates at block granularity.
- Drives the engine's blk_i/blk_valid.
- Tags each burst and demultiplexes engine output rows back to the originating path.

Parameters:
- ROW_W, 52, engine input row width (4 samples x 13 bit, signed, already sign-extended by requesters)
- OUT_W, 68, engine output row width (4 samples x 17 bit)
- TAG_DEPTH, 4, bursts allowed in flight inside the engine (tag FIFO depth, power of 2)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- fwd_valid  in  1  forward requester row valid
- fwd_row  in  ROW_W  forward requester row
- fwd_ready  out  1  forward row accepted this cycle
- rev_valid  in  1  reverse requester row valid
- rev_row  in  ROW_W  reverse requester row
- rev_ready  out  1  reverse row accepted this cycle
- eng_blk_o  out  ROW_W  row to engine blk_i
- eng_valid_o  out  1  to engine blk_valid
- eng_pix_i  in  OUT_W  engine {pix_out3..pix_out0}
- eng_pix_ivalid  in  1  engine pix_ovalid
- fwd_pix_o  out  OUT_W  output row routed to forward path
- fwd_pix_ovalid  out  1  forward output row valid
- rev_pix_o  out  OUT_W  output row routed to reverse path
- rev_pix_ovalid  out  1  reverse output row valid
- pix_last_o  out  1  marks 4th output row of a block (either path)
- busy  out  1  burst in progress or tag FIFO non-empty
- err  out  2  sticky: [0] valid dropped mid-burst, [1] orphan engine output

Behaviour:
- Reset values: all outputs 0, FSM IDLE, row counter 0, RR pointer favours fwd, tag FIFO empty, err 0.
- FSM IDLE:
  - Grant when some valid is high and tag FIFO is not full.
  - Both valid: round-robin, the last-granted loses.
  - Grant cycle is beat 0 (ready high combinationally that cycle), then go to BURST.
- FSM BURST:
  - Row counter runs 1..3; granted ready is held high every cycle, other ready is held 0.
  - At beat 3, re-arbitrate in the same cycle: a new grant gives beat 0 on the next cycle (no bubble); otherwise go to IDLE.
- Tag FIFO:
  - Push grant id (0=fwd, 1=rev) on beat 0.
  - Full means TAG_DEPTH entries; no grant while full; push while full is impossible by construction.
- Engine drive: eng_blk_o/eng_valid_o are registered, 1 cycle after acceptance; eng_valid_o=0 in IDLE, eng_blk_o holds its last value.
- Mid-burst valid drop by the granted requester:
  - Beat still consumed; eng_valid_o=1 with eng_blk_o=0 to preserve engine framing.
  - err[0] set.
  - Requesters must hold valid for 4 contiguous beats.
- Output demux:
  - Output row counter 0..3 counts eng_pix_ivalid beats.
  - Each row is routed to the head tag's path, registered (1-cycle latency); the other path's valid stays 0.
  - Pop on the 4th beat, which also asserts pix_last_o.
  - Push and pop in the same cycle are both honoured; count unchanged.
- Orphan: eng_pix_ivalid with FIFO empty drops the row and sets err[1]; the output counter does not advance.
- Reset mid-burst aborts everything and empties the FIFO; the engine must share the same rst_n.
- Width rule: pure routing; no arithmetic on data.

Optional Feature:
- Macro WHT_ARB_FWD_PRIO_EN.
- Defined: strict priority; fwd wins every contested grant; the rev path may starve while fwd streams.
- Undefined: round-robin as above; worst-case rev wait is one fwd burst.

Decomposition:
- Package wht_pkg holds:
  - localparam ROWS_PER_BLK=4
  - tag typedef/encoding (TAG_FWD=0, TAG_REV=1)
  - err bit indices
- One natural sub-module, wht_tag_fifo: parameterised depth, 1-bit data, push/pop/full/empty/count, simultaneous push+pop.

Test Plan:
- Single fwd block, rows 1..4, engine model latency 5:
  - fwd_ready high 4 cycles from grant.
  - eng_valid_o 4 beats 1 cycle later.
  - 4 fwd_pix_ovalid beats; pix_last_o on the 4th; rev outputs stay 0.
- fwd and rev valid continuously:
  - Grants alternate F,R,F,R at 4-cycle spacing with no eng_valid_o gap.
  - Outputs route F,R,F,R.
  - With WHT_ARB_FWD_PRIO_EN: F only.
- Engine latency forced to 20 cycles with both streaming:
  - After 4 bursts, grants stall (busy=1, both ready 0).
  - Grants resume the cycle after the first pop.
- fwd_valid dropped on beat 2:
  - Engine row 2 = 0 with eng_valid_o=1; err=2'b01.
  - Next burst unaffected.
- eng_pix_ivalid pulse while idle: err=2'b10; no pix valid on either output.
- rst_n asserted during beat 2:
  - All outputs 0 immediately; FIFO empty.
  - Post-reset first contested grant goes to fwd.

Source files
------------

// File: rtl/wht_2d_arb_pkg.sv
// Shared types and constants for the wht_2d engine arbiter.
// Pure declarations, no logic.
// Tag encoding identifies which requester a block belongs to.
package wht_pkg;

  localparam int ROWS_PER_BLK = 4;

  // Burst owner, stored in the tag FIFO while the block is inside the engine
  typedef enum logic {
    TAG_FWD = 1'b0,
    TAG_REV = 1'b1
  } tag_e;

  // Arbiter FSM states
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  // Sticky error bit positions
  localparam int ERR_DROP   = 0;
  localparam int ERR_ORPHAN = 1;

endpackage

// File: rtl/wht_2d_arb_tag_fifo.sv
// Tag FIFO: 1-bit burst owner per block in flight inside the engine.
// Latency: pop_dat shows the head combinationally; push visible next cycle.
// No internal backpressure; caller never pushes when full or pops when empty.
module wht_tag_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     push_dat,
  input  logic                     pop,
  output logic                     pop_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Pointer and occupancy update; DEPTH is a power of 2 so pointers wrap naturally
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (push) begin
      mem_d[wr_q] = push_dat;
      wr_d        = wr_q + AW'(1);
    end
    if (pop) begin
      rd_d = rd_q + AW'(1);
    end
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end

  // Storage and pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign pop_dat = mem_q[rd_q];
  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;

endmodule

// File: rtl/wht_2d_arb.sv
// Block-granular arbiter sharing one wht_2d engine between fwd and rev paths.
// Latency: engine drive 1 cycle after acceptance; output demux 1 cycle after eng_pix_ivalid.
// Backpressure: ready only to the granted requester; no grant while TAG_DEPTH blocks are in flight.
// Option: WHT_ARB_FWD_PRIO_EN makes fwd win every contested grant (default round-robin).
module wht_2d_arb
  import wht_pkg::*;
#(
  parameter int ROW_W     = 52,
  parameter int OUT_W     = 68,
  parameter int TAG_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fwd_valid,
  input  logic [ROW_W-1:0] fwd_row,
  output logic             fwd_ready,
  input  logic             rev_valid,
  input  logic [ROW_W-1:0] rev_row,
  output logic             rev_ready,
  output logic [ROW_W-1:0] eng_blk_o,
  output logic             eng_valid_o,
  input  logic [OUT_W-1:0] eng_pix_i,
  input  logic             eng_pix_ivalid,
  output logic [OUT_W-1:0] fwd_pix_o,
  output logic             fwd_pix_ovalid,
  output logic [OUT_W-1:0] rev_pix_o,
  output logic             rev_pix_ovalid,
  output logic             pix_last_o,
  output logic             busy,
  output logic [1:0]       err
);

  localparam int         CW       = $clog2(TAG_DEPTH) + 1;
  localparam logic [1:0] LAST_ROW = 2'(ROWS_PER_BLK - 1);

  state_e           state_q, state_d;
  logic [1:0]       beat_q, beat_d;
  tag_e             gnt_q, gnt_d;
  tag_e             last_q, last_d;
  logic             run_q;
  tag_e             pick;
  tag_e             cur;
  logic             can_grant;
  logic             beat_act;
  logic             sel_vld;
  logic [ROW_W-1:0] sel_row;

  logic             tag_push, tag_pop, tag_full, tag_empty, tag_head;
  logic [CW-1:0]    tag_cnt;

  logic [ROW_W-1:0] eng_blk_q, eng_blk_d;
  logic             eng_vld_q, eng_vld_d;
  logic [OUT_W-1:0] fwd_pix_q, fwd_pix_d, rev_pix_q, rev_pix_d;
  logic             fwd_pvld_q, fwd_pvld_d, rev_pvld_q, rev_pvld_d;
  logic             plast_q, plast_d;
  logic [1:0]       out_cnt_q, out_cnt_d;
  logic [1:0]       err_q, err_d;
  logic             rx, orphan;

  wht_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tag_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (tag_push),
    .push_dat (pick),
    .pop      (tag_pop),
    .pop_dat  (tag_head),
    .full     (tag_full),
    .empty    (tag_empty),
    .count    (tag_cnt)
  );

  // Winner selection among current requesters; run_q keeps grants off while in reset
  always_comb begin
    can_grant = run_q && (fwd_valid || rev_valid) && !tag_full;
    if (fwd_valid && rev_valid) begin
`ifdef WHT_ARB_FWD_PRIO_EN
      pick = TAG_FWD;
`else
      pick = (last_q == TAG_FWD) ? TAG_REV : TAG_FWD;
`endif
    end else begin
      pick = fwd_valid ? TAG_FWD : TAG_REV;
    end
  end

  // Block FSM. The grant for the next block is taken on the cycle its beat 0 lands,
  // right after beat 3, so back-to-back blocks have no bubble and a requester's
  // valid is only ever judged for the row it is actually presenting.
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    gnt_d    = gnt_q;
    last_d   = last_q;
    beat_act = 1'b0;
    cur      = gnt_q;
    tag_push = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (can_grant) begin
          beat_act = 1'b1;
          cur      = pick;
          tag_push = 1'b1;
          gnt_d    = pick;
          last_d   = pick;
          beat_d   = 2'd1;
          state_d  = ST_BURST;
        end
      end
      default: begin
        beat_act = 1'b1;
        beat_d   = beat_q + 2'd1;
        if (beat_q == LAST_ROW) begin
          beat_d  = 2'd0;
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  assign fwd_ready = beat_act && (cur == TAG_FWD);
  assign rev_ready = beat_act && (cur == TAG_REV);

  // Engine drive; a missing row still consumes its beat as zeros to keep engine framing
  always_comb begin
    sel_vld   = (cur == TAG_FWD) ? fwd_valid : rev_valid;
    sel_row   = (cur == TAG_FWD) ? fwd_row : rev_row;
    eng_vld_d = beat_act;
    eng_blk_d = eng_blk_q;
    if (beat_act) begin
      eng_blk_d = sel_vld ? sel_row : '0;
    end
  end

  // Output demux: route engine rows to the head tag's path, pop on the block's last row
  always_comb begin
    rx         = eng_pix_ivalid && !tag_empty;
    orphan     = eng_pix_ivalid && tag_empty;
    tag_pop    = rx && (out_cnt_q == LAST_ROW);
    out_cnt_d  = rx ? out_cnt_q + 2'd1 : out_cnt_q;
    fwd_pvld_d = rx && (tag_e'(tag_head) == TAG_FWD);
    rev_pvld_d = rx && (tag_e'(tag_head) == TAG_REV);
    fwd_pix_d  = fwd_pvld_d ? eng_pix_i : fwd_pix_q;
    rev_pix_d  = rev_pvld_d ? eng_pix_i : rev_pix_q;
    plast_d    = tag_pop;
    err_d      = err_q;
    if (beat_act && !sel_vld) err_d[ERR_DROP] = 1'b1;
    if (orphan)               err_d[ERR_ORPHAN] = 1'b1;
  end

  // Control state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      beat_q  <= 2'd0;
      gnt_q   <= TAG_FWD;
      last_q  <= TAG_REV;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      run_q   <= 1'b1;
    end
  end

  // Registered datapath outputs and sticky errors
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eng_blk_q  <= '0;
      eng_vld_q  <= 1'b0;
      fwd_pix_q  <= '0;
      rev_pix_q  <= '0;
      fwd_pvld_q <= 1'b0;
      rev_pvld_q <= 1'b0;
      plast_q    <= 1'b0;
      out_cnt_q  <= 2'd0;
      err_q      <= 2'b00;
    end else begin
      eng_blk_q  <= eng_blk_d;
      eng_vld_q  <= eng_vld_d;
      fwd_pix_q  <= fwd_pix_d;
      rev_pix_q  <= rev_pix_d;
      fwd_pvld_q <= fwd_pvld_d;
      rev_pvld_q <= rev_pvld_d;
      plast_q    <= plast_d;
      out_cnt_q  <= out_cnt_d;
      err_q      <= err_d;
    end
  end

  assign eng_blk_o      = eng_blk_q;
  assign eng_valid_o    = eng_vld_q;
  assign fwd_pix_o      = fwd_pix_q;
  assign fwd_pix_ovalid = fwd_pvld_q;
  assign rev_pix_o      = rev_pix_q;
  assign rev_pix_ovalid = rev_pvld_q;
  assign pix_last_o     = plast_q;
  assign busy           = (state_q == ST_BURST) || (tag_cnt != '0);
  assign err            = err_q;

endmodule
